hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_pkg.sv | 21 ++
 rtl/hazard_ctrl_load_use_detect.sv | 27 ++
 rtl/hazard_ctrl.sv | 117 +++++++++++
 tb/tb_hazard_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2,
    ST_WAIT  = 2'd3
  } state_e;

  localparam logic [5:0]  OP_RTYPE = 6'h00;
  localparam logic [5:0]  OP_BEQ   = 6'h04;
  localparam logic [5:0]  OP_BNE   = 6'h05;
  localparam logic [5:0]  OP_SW    = 6'h2B;

  localparam logic [31:0] NOP_INSTR = 32'h0;

  localparam int CNT_W  = 16;
  localparam int WAIT_W = 8;

endpackage

// File: rtl/hazard_ctrl_load_use_detect.sv
// Load-use comparator: flags an IF/ID instruction that reads the register an in-flight load writes.
module load_use_detect
  import hazard_ctrl_pkg::*;
(
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rt,
  input  logic [15:0] id_hi,
  output logic        lu
);

  logic [5:0] opcode;
  logic [4:0] rs;
  logic [4:0] rt;
  logic       rt_is_src;

  assign opcode = id_hi[15:10];
  assign rs     = id_hi[9:5];
  assign rt     = id_hi[4:0];

  // Only these formats read rt as a source operand.
  assign rt_is_src = (opcode == OP_RTYPE) || (opcode == OP_BEQ) ||
                     (opcode == OP_BNE)   || (opcode == OP_SW);

  assign lu = ex_mem_read && (ex_rt != 5'd0) &&
              ((ex_rt == rs) || ((ex_rt == rt) && rt_is_src));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: branch flush, load-use stall and imem wait handling with counters.
//   state    | meaning
//   ST_RUN   | last cycle advanced normally
//   ST_STALL | last cycle held IF/ID for a load-use hazard
//   ST_FLUSH | last cycle flushed for a taken branch
//   ST_WAIT  | last cycle waited on instruction memory
module hazard_ctrl
  import hazard_ctrl_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              imem_ready,
  input  logic [31:0]       id_instr,
  input  logic              ex_mem_read,
  input  logic [4:0]        ex_rt,
  input  logic              ex_branch_taken,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              if_id_flush,
  output logic              id_ex_bubble,
  output logic [1:0]        state,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
  output logic              imem_timeout
);

  logic              lu;
  state_e            act;
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic [WAIT_W-1:0] wait_run_q, wait_run_d;
  logic              imem_timeout_q, imem_timeout_d;
  logic              unused_instr_lo;

  assign unused_instr_lo = ^id_instr[15:0];

  load_use_detect u_load_use_detect (
    .ex_mem_read (ex_mem_read),
    .ex_rt       (ex_rt),
    .id_hi       (id_instr[31:16]),
    .lu          (lu)
  );

  always_comb begin
    if (ex_branch_taken)  act = ST_FLUSH;
    else if (lu)          act = ST_STALL;
    else if (!imem_ready) act = ST_WAIT;
    else                  act = ST_RUN;
  end

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    // Reset parks the pipe: PC frozen, NOP loaded, ID/EX bubbled.
    if (!reset_n) begin
      pc_write     = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else begin
      case (act)
        ST_FLUSH: begin
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
        end
        ST_STALL: begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
        end
        ST_WAIT: begin
          pc_write     = 1'b0;
          if_id_flush  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d     = act;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    wait_run_d  = '0;
    if (((act == ST_STALL) || (act == ST_WAIT)) && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 1'b1;
    if ((act == ST_FLUSH) && (flush_cnt_q != '1))
      flush_cnt_d = flush_cnt_q + 1'b1;
    if (act == ST_WAIT)
      wait_run_d = (wait_run_q == '1) ? wait_run_q : wait_run_q + 1'b1;
    imem_timeout_d = imem_timeout_q || (wait_run_d == '1);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_RUN;
      stall_cnt_q    <= '0;
      flush_cnt_q    <= '0;
      wait_run_q     <= '0;
      imem_timeout_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      stall_cnt_q    <= stall_cnt_d;
      flush_cnt_q    <= flush_cnt_d;
      wait_run_q     <= wait_run_d;
      imem_timeout_q <= imem_timeout_d;
    end
  end

  assign state        = state_q;
  assign stall_cnt    = stall_cnt_q;
  assign flush_cnt    = flush_cnt_q;
  assign imem_timeout = imem_timeout_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized and directed bench for hazard_ctrl against a behavioural reference model.
module tb_hazard_ctrl;

  logic        clock;
  logic        reset_n;
  logic        imem_ready;
  logic [31:0] id_instr;
  logic        ex_mem_read;
  logic [4:0]  ex_rt;
  logic        ex_branch_taken;
  logic        pc_write;
  logic        if_id_write;
  logic        if_id_flush;
  logic        id_ex_bubble;
  logic [1:0]  state;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;
  logic        imem_timeout;

  int n_checks = 0;
  int n_errors = 0;

  // reference model: 0=RUN 1=STALL 2=FLUSH 3=WAIT
  int m_state, m_stall, m_flush, m_wait_run;
  bit m_timeout;

  hazard_ctrl dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .imem_ready      (imem_ready),
    .id_instr        (id_instr),
    .ex_mem_read     (ex_mem_read),
    .ex_rt           (ex_rt),
    .ex_branch_taken (ex_branch_taken),
    .pc_write        (pc_write),
    .if_id_write     (if_id_write),
    .if_id_flush     (if_id_flush),
    .id_ex_bubble    (id_ex_bubble),
    .state           (state),
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt),
    .imem_timeout    (imem_timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit model_lu(input bit mr, input int rt, input logic [31:0] ins);
    int op, rs_f, rt_f;
    bit reads_rt;
    op   = int'(ins >> 26);
    rs_f = int'((ins >> 21) & 32'h1F);
    rt_f = int'((ins >> 16) & 32'h1F);
    reads_rt = (op == 0) || (op == 4) || (op == 5) || (op == 43);
    return mr && (rt != 0) && ((rt == rs_f) || (rt == rt_f && reads_rt));
  endfunction

  function automatic int model_act();
    if (ex_branch_taken) return 2;
    if (model_lu(ex_mem_read, int'(ex_rt), id_instr)) return 1;
    if (!imem_ready) return 3;
    return 0;
  endfunction

  task automatic model_reset();
    m_state = 0; m_stall = 0; m_flush = 0; m_wait_run = 0; m_timeout = 0;
  endtask

  task automatic check_ctrl(input int act);
    bit [3:0] e;
    case (act)
      2: e = 4'b1111;
      1: e = 4'b0001;
      3: e = 4'b0110;
      default: e = 4'b1100;
    endcase
    check_val("pc_write",     32'(pc_write),     32'(e[3]));
    check_val("if_id_write",  32'(if_id_write),  32'(e[2]));
    check_val("if_id_flush",  32'(if_id_flush),  32'(e[1]));
    check_val("id_ex_bubble", 32'(id_ex_bubble), 32'(e[0]));
  endtask

  task automatic check_regs();
    check_val("state",        32'(state),        32'(m_state));
    check_val("stall_cnt",    32'(stall_cnt),    32'(m_stall));
    check_val("flush_cnt",    32'(flush_cnt),    32'(m_flush));
    check_val("imem_timeout", 32'(imem_timeout), 32'(m_timeout));
  endtask

  // Inputs are already driven; check outputs, clock once, update model, check registers.
  task automatic run_cycle(input bit chk_regs);
    int act;
    act = model_act();
    #1;
    check_ctrl(act);
    @(posedge clock);
    m_state = act;
    if (act == 1 || act == 3) m_stall = (m_stall < 65535) ? m_stall + 1 : 65535;
    if (act == 2) m_flush = (m_flush < 65535) ? m_flush + 1 : 65535;
    m_wait_run = (act == 3) ? ((m_wait_run < 255) ? m_wait_run + 1 : 255) : 0;
    if (m_wait_run == 255) m_timeout = 1;
    #1;
    if (chk_regs) check_regs();
  endtask

  task automatic drive(input bit rdy, input logic [31:0] ins, input bit mr, input logic [4:0] rt, input bit br);
    imem_ready = rdy; id_instr = ins; ex_mem_read = mr; ex_rt = rt; ex_branch_taken = br;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    #1;
    check_ctrl_reset();
    check_regs();
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic check_ctrl_reset();
    check_val("rst_pc_write",     32'(pc_write),     32'd0);
    check_val("rst_if_id_write",  32'(if_id_write),  32'd1);
    check_val("rst_if_id_flush",  32'(if_id_flush),  32'd1);
    check_val("rst_id_ex_bubble", 32'(id_ex_bubble), 32'd1);
  endtask

  function automatic logic [31:0] rand_instr(input logic [4:0] hot);
    logic [5:0] op;
    logic [4:0] rs, rt;
    logic [2:0] pick;
    pick = 3'($urandom_range(0, 5));
    case (pick)
      0: op = 6'h00;
      1: op = 6'h04;
      2: op = 6'h05;
      3: op = 6'h2B;
      4: op = 6'h23;
      default: op = 6'($urandom);
    endcase
    rs = ($urandom_range(0, 2) == 0) ? hot : 5'($urandom);
    rt = ($urandom_range(0, 2) == 0) ? hot : 5'($urandom);
    return {op, rs, rt, 16'($urandom)};
  endfunction

  initial begin
    logic [4:0] hot;
    drive(1'b1, 32'h0, 1'b0, 5'd0, 1'b0);
    reset_n = 1'b0;
    model_reset();
    @(posedge clock);
    #1;
    // Reset values hold regardless of inputs.
    drive(1'b0, 32'h01095020, 1'b1, 5'd8, 1'b0);
    #1;
    check_ctrl_reset();
    check_regs();
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    // Load-use on rs with an R-type add.
    drive(1'b1, 32'h01095020, 1'b1, 5'd8, 1'b0);
    run_cycle(1);
    check_val("lu_state_stall", 32'(state), 32'd1);
    check_val("lu_stall_cnt",   32'(stall_cnt), 32'd1);

    do_reset();
    drive(1'b1, 32'h01095020, 1'b1, 5'd0, 1'b0);
    run_cycle(1);
    check_val("rt0_stall_cnt", 32'(stall_cnt), 32'd0);

    do_reset();
    drive(1'b1, 32'h01095020, 1'b1, 5'd8, 1'b1);
    run_cycle(1);
    check_val("br_flush_cnt", 32'(flush_cnt), 32'd1);
    check_val("br_stall_cnt", 32'(stall_cnt), 32'd0);
    check_val("br_state",     32'(state),     32'd2);

    // rt match only counts for formats that read rt: lw does not, sw does.
    do_reset();
    drive(1'b1, {6'h23, 5'd1, 5'd9, 16'h0}, 1'b1, 5'd9, 1'b0);
    run_cycle(1);
    drive(1'b1, {6'h2B, 5'd1, 5'd9, 16'h0}, 1'b1, 5'd9, 1'b0);
    run_cycle(1);

    // Randomized mix.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      hot = 5'($urandom_range(0, 4));
      drive(($urandom_range(0, 3) != 0), rand_instr(hot), $urandom_range(0, 1) == 1,
            hot, ($urandom_range(0, 7) == 0));
      run_cycle(1);
    end

    // Branch and lu both override wait and clear the wait run.
    do_reset();
    for (int i = 0; i < 200; i++) begin
      drive(1'b0, 32'h0, 1'b0, 5'd0, 1'b0);
      run_cycle(1);
    end
    drive(1'b0, 32'h0, 1'b0, 5'd0, 1'b1);
    run_cycle(1);
    for (int i = 0; i < 200; i++) begin
      drive(1'b0, 32'h0, 1'b0, 5'd0, 1'b0);
      run_cycle(1);
    end
    drive(1'b0, 32'h01095020, 1'b1, 5'd8, 1'b0);
    run_cycle(1);
    check_val("no_timeout_after_breaks", 32'(imem_timeout), 32'd0);

    // 255-cycle wait sets the sticky timeout.
    do_reset();
    for (int i = 0; i < 255; i++) begin
      drive(1'b0, 32'h0, 1'b0, 5'd0, 1'b0);
      run_cycle(1);
    end
    check_val("wait255_timeout", 32'(imem_timeout), 32'd1);
    check_val("wait255_stall",   32'(stall_cnt),    32'd255);
    drive(1'b1, 32'h0, 1'b0, 5'd0, 1'b0);
    run_cycle(1);
    check_val("timeout_sticky", 32'(imem_timeout), 32'd1);

    // Reset mid-wait abandons the run immediately.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 32'h0, 1'b0, 5'd0, 1'b0);
      run_cycle(1);
    end
    check_val("pre_rst_stall", 32'(stall_cnt), 32'd10);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_ctrl_reset();
    check_regs();
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    drive(1'b1, 32'h0, 1'b0, 5'd0, 1'b0);
    run_cycle(1);
    check_val("post_rst_run", 32'(state), 32'd0);

    // Saturation of stall_cnt.
    do_reset();
    drive(1'b1, 32'h01095020, 1'b1, 5'd8, 1'b0);
    for (int i = 0; i < 70000; i++) run_cycle(i >= 65530);
    check_val("stall_sat", 32'(stall_cnt), 32'hFFFF);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
